// File: rtl/alu_pkg.sv
// Shared types for the ALU writeback stage: opcode enum, status flags, FIFO entry,
// and a reference ALU model used by the optional result checker.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SHL = 3'b010,
    OP_SHR = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef struct packed {
    alu_op_e    op;
    logic [7:0] result;
    alu_flags_t flags;
  } wb_entry_t;

  // Shift amounts of 8 or more clear the operand completely.
  function automatic logic [7:0] alu_ref(input alu_op_e op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    case (op)
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_SHL: r = (b >= 8'd8) ? 8'h00 : (a << b[2:0]);
      OP_SHR: r = (b >= 8'd8) ? 8'h00 : (a >> b[2:0]);
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO of wb_entry_t; pointers and count are
// reset, storage is not (stale entries are never visible once count is cleared).
module sync_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                wr_data,
  output wb_entry_t                rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/alu_writeback_fifo.sv
// ALU writeback stage: derives N/Z/C/V at push time and buffers entries in a FIFO.
// Optional result checker enabled by defining ALU_WB_CHECK_EN.
module alu_writeback_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_select,
  input  logic [7:0]             in_a,
  input  logic [7:0]             in_b,
  input  logic [7:0]             in_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_select,
  output logic [7:0]             out_result,
  output logic [3:0]             out_flags,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       accepted,
  output logic                   mismatch
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             push, pop;
  wb_entry_t        wr_entry, head;
  logic [CW-1:0]    fifo_count;
  logic [CNT_W-1:0] accepted_q, accepted_d;

  // C/V come from the operands (true adder carry/overflow); N/Z from the presented result.
  function automatic alu_flags_t calc_flags(input alu_op_e op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] res);
    alu_flags_t        f;
    logic [8:0]        sum9;
    logic signed [7:0] sa, sb, sr;
    sa   = $signed(a);
    sb   = $signed(b);
    sum9 = 9'd0;
    f.n  = res[7];
    f.z  = (res == 8'h00);
    f.c  = 1'b0;
    f.v  = 1'b0;
    case (op)
      OP_ADD: begin
        sum9 = {1'b0, a} + {1'b0, b};
        sr   = $signed(sum9[7:0]);
        f.c  = sum9[8];
        f.v  = (sa[7] == sb[7]) && (sr[7] != sa[7]);
      end
      OP_SUB: begin
        sum9 = {1'b0, a} + {1'b0, ~b} + 9'd1;
        sr   = $signed(sum9[7:0]);
        f.c  = sum9[8];
        f.v  = (sa[7] != sb[7]) && (sr[7] != sa[7]);
      end
      default: sr = 8'sd0;
    endcase
    return f;
  endfunction

  assign in_ready  = (fifo_count != CW'(DEPTH));
  assign out_valid = (fifo_count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_entry.op     = alu_op_e'(in_select);
    wr_entry.result = in_result;
    wr_entry.flags  = calc_flags(alu_op_e'(in_select), in_a, in_b, in_result);
  end

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (fifo_count)
  );

  always_comb begin
    accepted_d = accepted_q + CNT_W'(push);
  end

  always_ff @(posedge clock) begin
    if (!reset) accepted_q <= '0;
    else        accepted_q <= accepted_d;
  end

  // Empty FIFO presents zeros rather than stale storage.
  assign out_select = out_valid ? head.op     : 3'b000;
  assign out_result = out_valid ? head.result : 8'h00;
  assign out_flags  = out_valid ? head.flags  : 4'b0000;
  assign count      = fifo_count;
  assign accepted   = accepted_q;

`ifdef ALU_WB_CHECK_EN
  logic mismatch_q, mismatch_d;

  always_comb begin
    mismatch_d = mismatch_q;
    if (push && (alu_ref(alu_op_e'(in_select), in_a, in_b) != in_result)) mismatch_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) mismatch_q <= 1'b0;
    else        mismatch_q <= mismatch_d;
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_writeback_fifo.sv
// Directed bench for alu_writeback_fifo: flag vector table plus full/stall,
// mid-stream reset and result-checker sequences.
module tb_alu_writeback_fifo;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, mismatch;
  logic [2:0]  in_select, out_select;
  logic [7:0]  in_a, in_b, in_result, out_result;
  logic [3:0]  out_flags;
  logic [2:0]  count;
  logic [15:0] accepted;

  int errors = 0;
  int checks = 0;
  int exp_acc = 0;

  always #5 clock = ~clock;

  alu_writeback_fifo #(.DEPTH(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_select(in_select), .in_a(in_a), .in_b(in_b), .in_result(in_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_select(out_select), .out_result(out_result), .out_flags(out_flags),
    .count(count), .accepted(accepted), .mismatch(mismatch)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flags;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] r);
    in_valid = v; in_select = s; in_a = a; in_b = b; in_result = r;
  endtask

  logic exp_mis;

  initial begin
    vecs[0] = '{3'b000, 8'hFF, 8'h01, 8'h00, 4'b0110};
    vecs[1] = '{3'b001, 8'h80, 8'h01, 8'h7F, 4'b0011};
    vecs[2] = '{3'b001, 8'h01, 8'h02, 8'hFF, 4'b1000};
    vecs[3] = '{3'b000, 8'h7F, 8'h01, 8'h80, 4'b1001};
    vecs[4] = '{3'b100, 8'hF0, 8'h0F, 8'h00, 4'b0100};
    vecs[5] = '{3'b010, 8'h81, 8'h01, 8'h02, 4'b0000};
    vecs[6] = '{3'b111, 8'h00, 8'h00, 8'hFF, 4'b1000};
    vecs[7] = '{3'b001, 8'h05, 8'h05, 8'h00, 4'b0110};
    vecs[8] = '{3'b000, 8'h80, 8'h80, 8'h00, 4'b0111};
    vecs[9] = '{3'b011, 8'h80, 8'h09, 8'h00, 4'b0100};

    reset = 1'b0; out_ready = 1'b0;
    drive(1'b0, 3'b000, 8'h00, 8'h00, 8'h00);
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_accepted", 32'(accepted), 0);
    chk("rst_mismatch", 32'(mismatch), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_result", 32'(out_result), 0);
    chk("rst_out_flags", 32'(out_flags), 0);
    reset = 1'b1;
    tick();

    // Flag table: push one entry, inspect head, then pop it.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].res);
      out_ready = 1'b0;
      tick();
      exp_acc++;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("vec%0d_select", i), 32'(out_select), 32'(vecs[i].sel));
      chk($sformatf("vec%0d_result", i), 32'(out_result), 32'(vecs[i].res));
      chk($sformatf("vec%0d_flags", i), 32'(out_flags), 32'(vecs[i].flags));
      chk($sformatf("vec%0d_accepted", i), 32'(accepted), 32'(exp_acc));
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk($sformatf("vec%0d_drained", i), 32'(count), 0);
    end
    chk("table_mismatch", 32'(mismatch), 0);

    // Fill with consumer stalled; fifth tuple must be refused.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'b000, 8'(8'h10 + i), 8'h00, 8'(8'h10 + i));
      tick();
      if (i < 4) exp_acc++;
    end
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_accepted", 32'(accepted), 32'(exp_acc));
    chk("full_head", 32'(out_result), 32'h10);

    // Full with both sides active: pop only, then push+pop together.
    drive(1'b1, 3'b000, 8'h20, 8'h00, 8'h20);
    out_ready = 1'b1;
    tick();
    chk("fullpop_count", 32'(count), 3);
    chk("fullpop_accepted", 32'(accepted), 32'(exp_acc));
    chk("fullpop_head", 32'(out_result), 32'h11);
    tick();
    exp_acc++;
    chk("pushpop_count", 32'(count), 3);
    chk("pushpop_accepted", 32'(accepted), 32'(exp_acc));
    chk("pushpop_head", 32'(out_result), 32'h12);
    in_valid = 1'b0;
    tick();
    chk("order_head1", 32'(out_result), 32'h13);
    tick();
    chk("order_head2", 32'(out_result), 32'h20);
    tick();
    chk("drain_count", 32'(count), 0);
    chk("drain_valid", 32'(out_valid), 0);

    // Mid-stream reset flushes everything in one edge.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b101, 8'h01, 8'h02, 8'h03);
      tick();
    end
    chk("pre_rst_count", 32'(count), 3);
    reset = 1'b0; out_ready = 1'b1;
    tick();
    chk("midrst_count", 32'(count), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_accepted", 32'(accepted), 0);
    chk("midrst_result", 32'(out_result), 0);
    reset = 1'b1; out_ready = 1'b0;
    drive(1'b1, 3'b110, 8'h5A, 8'h00, 8'h5A);
    tick();
    chk("postrst_head", 32'(out_result), 32'h5A);
    chk("postrst_count", 32'(count), 1);
    chk("postrst_accepted", 32'(accepted), 1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();

`ifdef ALU_WB_CHECK_EN
    exp_mis = 1'b1;
`else
    exp_mis = 1'b0;
`endif
    // Wrong XOR result, then a correct op: mismatch must stick.
    drive(1'b1, 3'b110, 8'h0F, 8'hF0, 8'h00);
    tick();
    chk("bad_xor_mismatch", 32'(mismatch), 32'(exp_mis));
    chk("bad_xor_flags", 32'(out_flags), 32'b0100);
    drive(1'b1, 3'b000, 8'h02, 8'h03, 8'h05);
    tick();
    chk("sticky_mismatch", 32'(mismatch), 32'(exp_mis));
    in_valid = 1'b0;
    tick();
    chk("sticky_idle_mismatch", 32'(mismatch), 32'(exp_mis));
    reset = 1'b0;
    tick();
    chk("mismatch_cleared", 32'(mismatch), 0);
    reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
